// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the data memory controller.
// The master side issues loads and stores; the slave side answers with a
// one-cycle response pulse and exports a live view of one memory word.
interface data_mem_ctrl_if #(
   parameter int AW = 7
);
   logic          req;
   logic          we;
   logic [1:0]    size;
   logic          sext;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic          ready;
   logic [31:0]   rdata;
   logic          rvalid;
   logic          err;
   logic [31:0]   probe;

   modport master (
      output req, we, size, sext, addr, wdata,
      input  ready, rdata, rvalid, err, probe
   );

   modport slave (
      input  req, we, size, sext, addr, wdata,
      output ready, rdata, rvalid, err, probe
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: a word-organised register memory with byte,
// halfword and word access, sign/zero extension on loads and a misalignment
// flag. After reset the memory is swept once, one word per cycle, to its
// initial image before requests are accepted.
module data_mem_ctrl #(
   parameter int DEPTH      = 32,
   parameter int INIT_COUNT = 9,
   parameter int PROBE_WORD = 5
) (
   input logic            clk,
   input logic            rst,
   data_mem_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH) + 2;
   localparam int WW = $clog2(DEPTH);
   localparam logic [WW-1:0] LAST_WORD = WW'(DEPTH - 1);
   localparam logic [WW-1:0] PROBE_IDX = WW'(PROBE_WORD);

   typedef enum logic {INIT, RUN} state_t;

   state_t        state;
   logic [WW-1:0] count;
   logic          ready_q;
   logic          rvalid_q;
   logic          err_q;
   logic [31:0]   rdata_q;

   logic [31:0]   mem [DEPTH];

   logic [WW-1:0] word_idx;
   logic [1:0]    lane;
   logic          misaligned;
   logic [31:0]   rd_word;
   logic [31:0]   load_val;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [31:0]   init_val;

   logic [3:0]    wr_be;
   logic [WW-1:0] wr_idx;
   logic [31:0]   wr_data;

   assign word_idx = bus.addr[AW-1:2];
   assign lane     = bus.addr[1:0];
   assign init_val = (int'(count) < INIT_COUNT) ? 32'(count) : 32'd0;

   // Alignment rule: halfwords need an even address, words a multiple of four,
   // and the reserved size code is always rejected.
   always_comb begin
      misaligned = 1'b0;
      case (bus.size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = lane[0];
         2'b10:   misaligned = (lane != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

   // Load path: pick the addressed lane(s) and right-align them with the requested extension.
   always_comb begin
      rd_word  = mem[word_idx];
      rd_byte  = rd_word[{lane, 3'b000} +: 8];
      rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
      load_val = rd_word;
      case (bus.size)
         2'b00:   load_val = bus.sext ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
         2'b01:   load_val = bus.sext ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
         default: load_val = rd_word;
      endcase
   end

   // Single write port shared by the init sweep and aligned stores; reset blocks any write on its edge.
   always_comb begin
      wr_be   = 4'b0000;
      wr_idx  = count;
      wr_data = 32'd0;
      if (!rst) begin
         if (state == INIT) begin
            wr_be   = 4'b1111;
            wr_idx  = count;
            wr_data = init_val;
         end else if (bus.req && bus.we && !misaligned) begin
            wr_idx = word_idx;
            case (bus.size)
               2'b00: begin
                  wr_be   = 4'b0001 << lane;
                  wr_data = {4{bus.wdata[7:0]}};
               end
               2'b01: begin
                  wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                  wr_data = {2{bus.wdata[15:0]}};
               end
               default: begin
                  wr_be   = 4'b1111;
                  wr_data = bus.wdata;
               end
            endcase
         end
      end
   end

   // Memory array with per-byte write enables; contents are not reset, the sweep rebuilds them.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (wr_be[b]) begin
            mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // Control FSM: sweep the memory in INIT, then answer one request per cycle in RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT;
         count    <= '0;
         ready_q  <= 1'b0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         case (state)
            INIT: begin
               rvalid_q <= 1'b0;
               err_q    <= 1'b0;
               rdata_q  <= 32'd0;
               count    <= count + WW'(1);
               if (count == LAST_WORD) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               rvalid_q <= bus.req;
               err_q    <= bus.req && misaligned;
               rdata_q  <= (bus.req && !bus.we && !misaligned) ? load_val : 32'd0;
            end
            default: begin
               state <= INIT;
               count <= '0;
            end
         endcase
      end
   end

   assign bus.ready  = ready_q;
   assign bus.rvalid = rvalid_q;
   assign bus.err    = err_q;
   assign bus.rdata  = rdata_q;
   assign bus.probe  = mem[PROBE_IDX];
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus random
// traffic against a byte-addressed reference memory, with a scoreboard queue
// drained by an independent response monitor.
module tb_data_mem_ctrl;
   localparam int DEPTH      = 32;
   localparam int INIT_COUNT = 9;
   localparam int PROBE_WORD = 5;
   localparam int AW         = $clog2(DEPTH) + 2;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   logic clk = 1'b0;
   logic rst;

   resp_t       expQ[$];
   resp_t       monExp;
   logic [7:0]  refMem [DEPTH*4];
   int          assertCount = 0;
   int          failCount   = 0;

   data_mem_ctrl_if #(.AW(AW)) bus();

   data_mem_ctrl #(
      .DEPTH(DEPTH),
      .INIT_COUNT(INIT_COUNT),
      .PROBE_WORD(PROBE_WORD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Initial memory image: low words hold their own index, the rest are zero.
   function automatic void resetModel();
      for (int w = 0; w < DEPTH; w++) begin
         int val;
         val = (w < INIT_COUNT) ? w : 0;
         for (int b = 0; b < 4; b++) refMem[w*4 + b] = 8'(val >> (8*b));
      end
   endfunction

   function automatic bit isMisaligned(input logic [1:0] size, input int addr);
      return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
   endfunction

   function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic sext, input int addr);
      int          n;
      logic [31:0] v;
      n = 1 << size;
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(refMem[addr + i]) << (8*i));
      if (sext && n < 4 && v[8*n - 1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      return v;
   endfunction

   function automatic logic [31:0] modelWord(input int idx);
      return {refMem[idx*4 + 3], refMem[idx*4 + 2], refMem[idx*4 + 1], refMem[idx*4]};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Drive one request for one clock edge; the expected response is queued unless reset kills it.
   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sext,
                                input int addr, input logic [31:0] wdata, input bit withReset);
      bus.req   = 1'b1;
      bus.we    = we;
      bus.size  = size;
      bus.sext  = sext;
      bus.addr  = AW'(addr);
      bus.wdata = wdata;
      rst       = withReset;
      if (!withReset) begin
         if (isMisaligned(size, addr)) begin
            expQ.push_back('{rdata: 32'd0, err: 1'b1});
         end else if (we) begin
            for (int i = 0; i < (1 << size); i++) refMem[addr + i] = 8'(wdata >> (8*i));
            expQ.push_back('{rdata: 32'd0, err: 1'b0});
         end else begin
            expQ.push_back('{rdata: modelLoad(size, sext, addr), err: 1'b0});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.req = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Count edges until ready rises while a load is held on the bus, which must be ignored.
   task automatic waitReady(input string name, input int expected);
      int n;
      n = 0;
      bus.req  = 1'b1;
      bus.we   = 1'b0;
      bus.size = 2'd2;
      bus.addr = '0;
      while (n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.ready === 1'b1) break;
      end
      bus.req = 1'b0;
      checkOutput(name, 32'(n), 32'(expected));
   endtask

   // Response monitor: every rvalid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.rvalid === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("stray rvalid", 32'(bus.rvalid), 32'd0);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("response rdata", bus.rdata, monExp.rdata);
            checkOutput("response err", 32'(bus.err), 32'(monExp.err));
         end
      end
   end

   // Hard stop in case the run never reaches its summary.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      int t;
      rst       = 1'b1;
      bus.req   = 1'b0;
      bus.we    = 1'b0;
      bus.size  = 2'd0;
      bus.sext  = 1'b0;
      bus.addr  = '0;
      bus.wdata = 32'd0;
      resetModel();

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset ready", 32'(bus.ready), 32'd0);
      checkOutput("reset rvalid", 32'(bus.rvalid), 32'd0);
      checkOutput("reset err", 32'(bus.err), 32'd0);
      checkOutput("reset rdata", bus.rdata, 32'd0);

      rst = 1'b0;
      waitReady("ready latency", DEPTH);
      checkOutput("probe after init", bus.probe, 32'd5);

      $display("[TB] initial image loads");
      for (int i = 1; i <= 9; i++) applyStimulus(1'b0, 2'd2, 1'b0, 4*i, 32'd0, 1'b0);
      applyStimulus(1'b0, 2'd2, 1'b0, 80, 32'd0, 1'b0);
      idle(2);

      $display("[TB] byte store and extended loads");
      applyStimulus(1'b1, 2'd0, 1'b0, 'h15, 32'h000000A5, 1'b0);
      checkOutput("probe after byte store", bus.probe, 32'h0000A505);
      applyStimulus(1'b0, 2'd2, 1'b0, 'h14, 32'd0, 1'b0);
      applyStimulus(1'b0, 2'd0, 1'b1, 'h15, 32'd0, 1'b0);
      applyStimulus(1'b0, 2'd0, 1'b0, 'h15, 32'd0, 1'b0);
      idle(2);

      $display("[TB] halfword store and loads");
      applyStimulus(1'b1, 2'd1, 1'b0, 'h0E, 32'h00008001, 1'b0);
      applyStimulus(1'b0, 2'd1, 1'b1, 'h0E, 32'd0, 1'b0);
      applyStimulus(1'b0, 2'd2, 1'b0, 'h0C, 32'd0, 1'b0);
      idle(2);

      $display("[TB] misaligned accesses");
      applyStimulus(1'b1, 2'd2, 1'b0, 'h06, 32'hDEADBEEF, 1'b0);
      applyStimulus(1'b0, 2'd1, 1'b0, 'h03, 32'd0, 1'b0);
      applyStimulus(1'b0, 2'd3, 1'b0, 'h08, 32'd0, 1'b0);
      applyStimulus(1'b1, 2'd3, 1'b0, 'h04, 32'hFFFFFFFF, 1'b0);
      applyStimulus(1'b0, 2'd2, 1'b0, 'h04, 32'd0, 1'b0);
      idle(2);

      $display("[TB] store-then-load and load stream");
      applyStimulus(1'b1, 2'd2, 1'b0, 'h1C, 32'h12345678, 1'b0);
      applyStimulus(1'b0, 2'd2, 1'b0, 'h1C, 32'd0, 1'b0);
      applyStimulus(1'b0, 2'd2, 1'b0, 'h1C, 32'd0, 1'b0);
      applyStimulus(1'b0, 2'd2, 1'b0, 'h14, 32'd0, 1'b0);
      applyStimulus(1'b0, 2'd2, 1'b0, 'h0C, 32'd0, 1'b0);
      applyStimulus(1'b0, 2'd2, 1'b0, 'h04, 32'd0, 1'b0);
      idle(2);

      $display("[TB] reset in RUN after a load, with a store on the reset edge");
      applyStimulus(1'b1, 2'd2, 1'b0, 'h14, 32'hCAFEF00D, 1'b0);
      checkOutput("probe before reset", bus.probe, 32'hCAFEF00D);
      applyStimulus(1'b0, 2'd2, 1'b0, 'h00, 32'd0, 1'b0);
      applyStimulus(1'b1, 2'd2, 1'b0, 'h14, 32'h11111111, 1'b1);
      checkOutput("store dropped by reset", bus.probe, 32'hCAFEF00D);
      checkOutput("rvalid after run reset", 32'(bus.rvalid), 32'd0);
      checkOutput("ready after run reset", 32'(bus.ready), 32'd0);
      bus.req = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      resetModel();
      waitReady("ready after run reset", DEPTH);
      checkOutput("probe after re-init", bus.probe, 32'd5);

      $display("[TB] reset in the middle of the sweep");
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("ready mid-sweep reset", 32'(bus.ready), 32'd0);
      rst = 1'b0;
      resetModel();
      waitReady("ready after mid-sweep reset", DEPTH);
      checkOutput("probe after mid-sweep reset", bus.probe, 32'd5);

      $display("[TB] random traffic");
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else begin
            logic [1:0] sz;
            int         a;
            sz = 2'($urandom_range(0, 3));
            a  = int'($urandom_range(0, DEPTH*4 - 1));
            if (sz != 2'd3 && $urandom_range(0, 1) == 1) a = a & ~((1 << sz) - 1);
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
         end
         checkOutput("random probe", bus.probe, modelWord(PROBE_WORD));
      end
      idle(3);

      t = 0;
      while (expQ.size() != 0 && t < 10) begin
         @(posedge clk);
         t++;
      end
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
